readout_rx_bin_scheduler: RTL and testbench

Integration-window sequencer for the readout receive chain. It sits between the demodulated I/Q sample stream and the signed bin accumulator. On a trigger it skips a programmable number of samples, then drives the accumulator's `start_count` and `valid_in` to split the stream into consecutive bins. Each finished I/Q sum is captured into a single-entry output register with a valid/ready handshake toward the state discriminator.

---
 rtl/readout_rx_bin_scheduler_if.sv | 31 +++
 rtl/readout_rx_bin_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_readout_rx_bin_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_rx_bin_scheduler_if.sv
// Result bus from the bin scheduler to the state discriminator.
// Single-entry valid/ready handshake carrying one captured I/Q bin.
interface readout_rx_bin_scheduler_if #(
    parameter int ACCUMULATOR_WIDTH = 18,
    parameter int NBIN_WIDTH        = 4
);
    logic                                bin_valid;
    logic                                bin_ready;
    logic signed [ACCUMULATOR_WIDTH-1:0] bin_i;
    logic signed [ACCUMULATOR_WIDTH-1:0] bin_q;
    logic [NBIN_WIDTH-1:0]               bin_idx;
    logic                                bin_last;

    modport master (
        output bin_valid,
        output bin_i,
        output bin_q,
        output bin_idx,
        output bin_last,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_i,
        input  bin_q,
        input  bin_idx,
        input  bin_last,
        output bin_ready
    );
endinterface

// File: rtl/readout_rx_bin_scheduler.sv
// Integration-window sequencer: trigger -> sample delay -> N bins steering the accumulator; optional abort via READOUT_BIN_SCHED_ABORT_EN.
// Latency: a bin's result is visible one cycle after the accumulator absorbs its last sample.
// Backpressure: none on the sample stream; an unread result is overwritten and flags sticky overflow.
module readout_rx_bin_scheduler #(
    parameter int ACCUMULATOR_WIDTH = 18,
    parameter int LEN_WIDTH         = 10,
    parameter int NBIN_WIDTH        = 4
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef READOUT_BIN_SCHED_ABORT_EN
    input  logic                                abort,
`endif
    input  logic                                trigger,
    input  logic [LEN_WIDTH-1:0]                cfg_delay,
    input  logic [LEN_WIDTH-1:0]                cfg_bin_len,
    input  logic [NBIN_WIDTH-1:0]               cfg_num_bins,
    input  logic                                sample_valid,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] i_sum_in,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] q_sum_in,
    output logic                                acc_start_count,
    output logic                                acc_valid_in,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    readout_rx_bin_scheduler_if.master          bin_if
);

    typedef enum logic [1:0] {IDLE, DELAY, INTEG, FLUSH} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_WIDTH-1:0]   sample_cnt;
    logic [LEN_WIDTH-1:0]   sample_cnt_inc;
    logic [LEN_WIDTH-1:0]   delay_q;
    logic [LEN_WIDTH-1:0]   bin_len_q;
    logic [NBIN_WIDTH-1:0]  bin_cnt;
    logic [NBIN_WIDTH-1:0]  bin_cnt_inc;
    logic [NBIN_WIDTH-1:0]  num_bins_q;
    logic                   capture_pend;
    logic                   capture_now;
    logic                   accept;
    logic                   cnt_step;
    logic                   cnt_clr;
    logic                   bin_end;
    logic                   abort_hit;
    logic                   abort_req;

`ifdef READOUT_BIN_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sample_cnt_inc = sample_cnt + LEN_WIDTH'(1);
    assign bin_cnt_inc    = bin_cnt + NBIN_WIDTH'(1);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        acc_start_count = 1'b0;
        acc_valid_in    = 1'b0;
        accept          = 1'b0;
        cnt_step        = 1'b0;
        cnt_clr         = 1'b0;
        bin_end         = 1'b0;
        abort_hit       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    accept = 1'b1;
                    if (cfg_num_bins == '0) begin
                        state_nxt = FLUSH;
                    end else if (cfg_delay == '0) begin
                        state_nxt = INTEG;
                    end else begin
                        state_nxt = DELAY;
                    end
                end
            end
            DELAY: begin
                if (abort_req) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (sample_valid) begin
                    // The sample that completes the delay is itself discarded.
                    if (sample_cnt_inc == delay_q) begin
                        cnt_clr   = 1'b1;
                        state_nxt = INTEG;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            INTEG: begin
                if (abort_req) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (sample_valid) begin
                    acc_start_count = (sample_cnt == '0);
                    acc_valid_in    = (sample_cnt != '0);
                    if (sample_cnt_inc == bin_len_q) begin
                        cnt_clr = 1'b1;
                        bin_end = 1'b1;
                        if (bin_cnt_inc == num_bins_q) begin
                            state_nxt = FLUSH;
                        end
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_q      <= '0;
            bin_len_q    <= '0;
            num_bins_q   <= '0;
            sample_cnt   <= '0;
            bin_cnt      <= '0;
            capture_pend <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (accept) begin
                delay_q    <= cfg_delay;
                bin_len_q  <= (cfg_bin_len == '0) ? LEN_WIDTH'(1) : cfg_bin_len;
                num_bins_q <= cfg_num_bins;
                sample_cnt <= '0;
                bin_cnt    <= '0;
            end else if (cnt_clr || abort_hit) begin
                sample_cnt <= '0;
            end else if (cnt_step) begin
                sample_cnt <= sample_cnt_inc;
            end
            if (bin_end) begin
                bin_cnt <= bin_cnt_inc;
            end
            capture_pend <= bin_end;
            done         <= (state == FLUSH);
        end
    end

    // bin_cnt has already advanced past the completed bin when its capture fires.
    assign capture_now = capture_pend && !abort_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_if.bin_valid <= 1'b0;
            bin_if.bin_i     <= '0;
            bin_if.bin_q     <= '0;
            bin_if.bin_idx   <= '0;
            bin_if.bin_last  <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (capture_now) begin
                bin_if.bin_i     <= i_sum_in;
                bin_if.bin_q     <= q_sum_in;
                bin_if.bin_idx   <= bin_cnt - NBIN_WIDTH'(1);
                bin_if.bin_last  <= (state == FLUSH);
                bin_if.bin_valid <= 1'b1;
                if (bin_if.bin_valid && !bin_if.bin_ready) begin
                    overflow <= 1'b1;
                end
            end else if (bin_if.bin_valid && bin_if.bin_ready) begin
                bin_if.bin_valid <= 1'b0;
            end
            if (accept) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_readout_rx_bin_scheduler.sv
// Bench for readout_rx_bin_scheduler: directed measurement windows checked every cycle
// against an event-list model derived from the sample/bin timing rules.
module tb_readout_rx_bin_scheduler;
    localparam int AW = 18;
    localparam int LW = 10;
    localparam int NW = 4;
    localparam int W  = 48;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 trigger;
    logic [LW-1:0]        cfg_delay;
    logic [LW-1:0]        cfg_bin_len;
    logic [NW-1:0]        cfg_num_bins;
    logic                 sample_valid;
    logic signed [AW-1:0] i_sum_in;
    logic signed [AW-1:0] q_sum_in;
    logic                 acc_start_count;
    logic                 acc_valid_in;
    logic                 busy;
    logic                 done;
    logic                 overflow;
`ifdef READOUT_BIN_SCHED_ABORT_EN
    logic                 abort = 1'b0;
`endif

    readout_rx_bin_scheduler_if #(.ACCUMULATOR_WIDTH(AW), .NBIN_WIDTH(NW)) bif ();

    readout_rx_bin_scheduler #(.ACCUMULATOR_WIDTH(AW), .LEN_WIDTH(LW), .NBIN_WIDTH(NW)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef READOUT_BIN_SCHED_ABORT_EN
        .abort           (abort),
`endif
        .trigger         (trigger),
        .cfg_delay       (cfg_delay),
        .cfg_bin_len     (cfg_bin_len),
        .cfg_num_bins    (cfg_num_bins),
        .sample_valid    (sample_valid),
        .i_sum_in        (i_sum_in),
        .q_sum_in        (q_sum_in),
        .acc_start_count (acc_start_count),
        .acc_valid_in    (acc_valid_in),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .bin_if          (bif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int gcyc = 0;
    int cur = 0;

    bit trig_a[W], sv_a[W], rdy_a[W];
    bit e_start[W], e_vin[W], e_busy[W], e_done[W], e_cap[W], e_clr[W], e_lastf[W];
    int e_idx[W];

    logic                 m_valid, m_last, m_ovf, prev_rdy;
    logic signed [AW-1:0] m_i, m_q, prev_i, prev_q;
    logic [NW-1:0]        m_idx;
    int md, ms, od, os, ovin, ovn, first_start;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cur, got, exp);
        end
    endtask

    function automatic void fill(input int t1, input int t2, input int sv_mode, input int rdy_mode);
        for (int k = 0; k < W; k++) begin
            trig_a[k] = (k == t1) || (k == t2);
            sv_a[k]   = (sv_mode == 0) ? 1'b1 : (k % 2 == 0);
            case (rdy_mode)
                0:       rdy_a[k] = 1'b1;
                1:       rdy_a[k] = (k >= 30);
                default: rdy_a[k] = (k % 2 == 1);
            endcase
        end
    endfunction

    // Cycle k's inputs are sampled at the edge that opens cycle k+1.
    function automatic void compute_model(input int d, input int l, input int nb);
        int pos, ta, fin, e, c, eff_l;
        int s[$];
        for (int k = 0; k < W; k++) begin
            e_start[k] = 0; e_vin[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_cap[k] = 0; e_clr[k] = 0; e_lastf[k] = 0; e_idx[k] = 0;
        end
        eff_l = (l == 0) ? 1 : l;
        pos = 0;
        fin = 0;
        while (pos < W) begin
            ta = -1;
            for (int k = pos; k < W; k++) if (trig_a[k] && ta < 0) ta = k;
            if (ta < 0 || ta + 1 >= W) break;
            s.delete();
            for (int k = ta + 1; k < W; k++) if (sv_a[k]) s.push_back(k);
            e_clr[ta + 1] = 1;
            if (nb == 0) begin
                fin = ta + 1;
            end else begin
                if (s.size() < d + nb * eff_l) begin
                    $display("FAIL model_window cyc=%0d got=%0d exp=%0d", ta, s.size(), d + nb * eff_l);
                    $fatal(1, "window too short");
                end
                for (int b = 0; b < nb; b++) begin
                    for (int j = 0; j < eff_l; j++) begin
                        c = s[d + b * eff_l + j];
                        if (j == 0) e_start[c] = 1; else e_vin[c] = 1;
                    end
                    e = s[d + b * eff_l + eff_l - 1];
                    fin = e + 1;
                    if (e + 2 < W) begin
                        e_cap[e + 2]   = 1;
                        e_idx[e + 2]   = b;
                        e_lastf[e + 2] = (b == nb - 1);
                    end
                end
            end
            if (fin + 1 >= W) begin
                $display("FAIL model_window cyc=%0d got=%0d exp=%0d", ta, fin + 1, W - 1);
                $fatal(1, "window too short");
            end
            for (int k = ta + 1; k <= fin; k++) e_busy[k] = 1;
            e_done[fin + 1] = 1;
            pos = fin + 1;
        end
        md = -1;
        ms = 0;
        for (int k = 0; k < W; k++) begin
            if (e_done[k] && md < 0) md = k;
            if (e_start[k]) ms++;
        end
    endfunction

    task automatic run_window(input int d, input int l, input int nb);
        compute_model(d, l, nb);
        od = -1; os = 0; ovin = 0; ovn = 0; first_start = -1;
        for (int k = 0; k < W; k++) begin
            @(posedge clk);
            #1;
            gcyc++;
            trigger       = trig_a[k];
            sample_valid  = sv_a[k];
            bif.bin_ready = rdy_a[k];
            if (trig_a[k]) begin
                cfg_delay = LW'(d); cfg_bin_len = LW'(l); cfg_num_bins = NW'(nb);
            end else begin
                cfg_delay = LW'(7); cfg_bin_len = LW'(9); cfg_num_bins = NW'(5);
            end
            i_sum_in = AW'(gcyc * 97 - 3000);
            q_sum_in = AW'(11 - gcyc * 53);
            @(negedge clk);
            cur = k;
            if (e_clr[k]) m_ovf = 1'b0;
            if (e_cap[k]) begin
                if (m_valid && !prev_rdy) m_ovf = 1'b1;
                m_valid = 1'b1;
                m_i     = prev_i;
                m_q     = prev_q;
                m_idx   = NW'(e_idx[k]);
                m_last  = e_lastf[k];
            end else if (m_valid && prev_rdy) begin
                m_valid = 1'b0;
            end
            check("acc_start_count", acc_start_count, e_start[k]);
            check("acc_valid_in", acc_valid_in, e_vin[k]);
            check("busy", busy, e_busy[k]);
            check("done", done, e_done[k]);
            check("bin_valid", bif.bin_valid, m_valid);
            check("bin_i", bif.bin_i, m_i);
            check("bin_q", bif.bin_q, m_q);
            check("bin_idx", bif.bin_idx, m_idx);
            check("bin_last", bif.bin_last, m_last);
            check("overflow", overflow, m_ovf);
            if (acc_start_count) begin
                os++;
                if (first_start < 0) first_start = k;
            end
            if (acc_valid_in) ovin++;
            if (bif.bin_valid) ovn++;
            if (done && od < 0) od = k;
            prev_rdy = rdy_a[k];
            prev_i   = i_sum_in;
            prev_q   = q_sum_in;
        end
        cur = W;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bin_valid"}, bif.bin_valid, 0);
        check({tag, "_bin_i"}, bif.bin_i, 0);
        check({tag, "_bin_q"}, bif.bin_q, 0);
        check({tag, "_bin_idx"}, bif.bin_idx, 0);
        check({tag, "_bin_last"}, bif.bin_last, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_acc_start"}, acc_start_count, 0);
        check({tag, "_acc_vin"}, acc_valid_in, 0);
    endtask

    initial begin
        trigger = 1'b0; sample_valid = 1'b1; bif.bin_ready = 1'b0;
        cfg_delay = '0; cfg_bin_len = '0; cfg_num_bins = '0;
        i_sum_in = '0; q_sum_in = '0;
        m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; prev_rdy = 1'b0;
        m_i = '0; m_q = '0; m_idx = '0; prev_i = '0; prev_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur = -1;
        check_all_zero("reset");
        rst = 1'b1;

        // delay 3, bin_len 4, two bins
        fill(1, -1, 0, 0);
        run_window(3, 4, 2);
        check("t1_model_done", md, 14);
        check("t1_model_starts", ms, 2);
        check("t1_done_cycle", od, 14);
        check("t1_first_start", first_start, 5);
        check("t1_starts", os, 2);
        check("t1_vin", ovin, 6);
        check("t1_results", ovn, 2);

        // bin_len 1: every sample starts a bin, results on consecutive cycles
        fill(1, -1, 0, 0);
        run_window(0, 1, 3);
        check("t2_done_cycle", od, 6);
        check("t2_starts", os, 3);
        check("t2_vin", ovin, 0);
        check("t2_results", ovn, 3);

        // consumer stalled: second capture overwrites the first
        fill(1, -1, 0, 1);
        run_window(0, 2, 2);
        check("t3_done_cycle", od, 7);
        check("t3_overflow", overflow, 1);
        check("t3_bin_idx", bif.bin_idx, 1);
        check("t3_bin_last", bif.bin_last, 1);

        // empty measurement
        fill(1, -1, 0, 0);
        run_window(5, 3, 0);
        check("t4_model_done", md, 3);
        check("t4_done_cycle", od, 3);
        check("t4_results", ovn, 0);
        check("t4_starts", os, 0);
        check("t4_overflow", overflow, 0);

        // gapped samples, second trigger while busy
        fill(1, 6, 1, 0);
        run_window(1, 3, 2);
        check("t5_done_cycle", od, 16);
        check("t5_first_start", first_start, 4);
        check("t5_starts", os, 2);
        check("t5_vin", ovin, 4);
        check("t5_results", ovn, 2);

        // reset in the middle of INTEG with a result held
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            gcyc++;
            trigger = (k == 1); sample_valid = 1'b1; bif.bin_ready = 1'b0;
            cfg_delay = LW'(0); cfg_bin_len = LW'(3); cfg_num_bins = NW'(2);
            i_sum_in = AW'(gcyc * 97 - 3000);
            q_sum_in = AW'(11 - gcyc * 53);
        end
        @(negedge clk);
        cur = 6;
        check("t6_pre_valid", bif.bin_valid, 1);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_vin", acc_valid_in, 1);
        rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_i = '0; m_q = '0; m_idx = '0;
        prev_rdy = bif.bin_ready; prev_i = i_sum_in; prev_q = q_sum_in;

        // fresh run after reset; bin_len 0 acts as 1, alternating ready
        fill(1, -1, 0, 2);
        run_window(2, 0, 2);
        check("t7_done_cycle", od, 7);
        check("t7_starts", os, 2);
        check("t7_vin", ovin, 0);
        check("t7_overflow", overflow, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
